// File: rtl/ycbcr_coef_sequencer_if.sv
// Mode-request handshake and coefficient write bus of the YCbCr coefficient sequencer.
// master: the controller issuing mode requests and receiving the coefficient stream.
// slave: the sequencer itself.
interface ycbcr_coef_sequencer_if;
    logic [1:0]         mode_req;
    logic               mode_valid;
    logic               mode_ready;
    logic               coef_we;
    logic [3:0]         coef_addr;
    logic signed [17:0] coef_data;
    logic               coef_commit;
    logic [1:0]         mode_active;
    logic               cfg_err;

    modport master (
        output mode_req,
        output mode_valid,
        input  mode_ready,
        input  coef_we,
        input  coef_addr,
        input  coef_data,
        input  coef_commit,
        input  mode_active,
        input  cfg_err
    );

    modport slave (
        input  mode_req,
        input  mode_valid,
        output mode_ready,
        output coef_we,
        output coef_addr,
        output coef_data,
        output coef_commit,
        output mode_active,
        output cfg_err
    );
endinterface

// File: rtl/ycbcr_coef_sequencer.sv
// Loads one of three RGB->YCbCr coefficient sets into the converter's shadow registers
// at a frame start, then commits them in a single pulse so a frame never mixes two sets.
module ycbcr_coef_sequencer #(
    parameter bit VS_ACTIVE_HIGH = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  v_sync_in,
    ycbcr_coef_sequencer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StWaitVs, StLoad, StCommit} state_e;

    state_e             r_state;
    logic [1:0]         r_pend;
    logic [3:0]         r_idx;
    logic               r_vs;
    logic               r_ready;
    logic               r_we;
    logic [3:0]         r_addr;
    logic signed [17:0] r_data;
    logic               r_commit;
    logic [1:0]         r_active;
    logic               r_err;
    logic               w_frame_start;

    // Q1.17 coefficients; row order RY,GY,BY,RCb,GCb,BCb,RCr,GCr,BCr.
    // Luma-only keeps BT.601 Y and zeroes chroma so Cb/Cr collapse to the datapath offset.
    function automatic logic signed [17:0] coef_lut(input logic [1:0] mode,
                                                    input logic [3:0] idx);
        logic signed [17:0] v;
        logic               bt709;
        bt709 = (mode == 2'd1);
        v     = '0;
        case (idx)
            4'd0:    v = bt709 ? 18'sd27866  : 18'sd39191;
            4'd1:    v = bt709 ? 18'sd93743  : 18'sd76939;
            4'd2:    v = bt709 ? 18'sd9463   : 18'sd14942;
            4'd3:    v = bt709 ? -18'sd15017 : -18'sd22117;
            4'd4:    v = bt709 ? -18'sd50519 : -18'sd43419;
            4'd5:    v = 18'sd65536;
            4'd6:    v = 18'sd65536;
            4'd7:    v = bt709 ? -18'sd59527 : -18'sd54878;
            4'd8:    v = bt709 ? -18'sd6009  : -18'sd10658;
            default: v = '0;
        endcase
        if (mode == 2'd2 && idx > 4'd2) begin
            v = '0;
        end
        return v;
    endfunction

    // Frame start is the active-going edge of v_sync against its one-cycle history.
    always_comb begin
        if (VS_ACTIVE_HIGH) begin
            w_frame_start = v_sync_in & ~r_vs;
        end else begin
            w_frame_start = ~v_sync_in & r_vs;
        end
    end

    // v_sync history; resets to the inactive level so only a real transition counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs <= ~VS_ACTIVE_HIGH;
        end else begin
            r_vs <= v_sync_in;
        end
    end

    // Sequencer FSM with all outputs registered; strobes default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StWaitVs;
            r_pend   <= 2'd0;
            r_idx    <= 4'd0;
            r_ready  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 4'd0;
            r_data   <= '0;
            r_commit <= 1'b0;
            r_active <= 2'd0;
            r_err    <= 1'b0;
        end else begin
            r_we     <= 1'b0;
            r_addr   <= 4'd0;
            r_data   <= '0;
            r_commit <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_ready <= 1'b1;
                    if (r_ready && bus.mode_valid) begin
                        if (bus.mode_req == 2'd3) begin
                            // Reserved mode: flag it and keep accepting requests.
                            r_err <= 1'b1;
                        end else begin
                            r_pend  <= bus.mode_req;
                            r_ready <= 1'b0;
                            r_state <= StWaitVs;
                        end
                    end
                end
                StWaitVs: begin
                    if (w_frame_start) begin
                        r_idx   <= 4'd0;
                        r_state <= StLoad;
                    end
                end
                StLoad: begin
                    r_we   <= 1'b1;
                    r_addr <= r_idx;
                    r_data <= coef_lut(r_pend, r_idx);
                    if (r_idx == 4'd8) begin
                        r_state <= StCommit;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                StCommit: begin
                    r_commit <= 1'b1;
                    r_active <= r_pend;
                    r_state  <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.mode_ready  = r_ready;
    assign bus.coef_we     = r_we;
    assign bus.coef_addr   = r_addr;
    assign bus.coef_data   = r_data;
    assign bus.coef_commit = r_commit;
    assign bus.mode_active = r_active;
    assign bus.cfg_err     = r_err;

endmodule

// File: tb/tb_ycbcr_coef_sequencer.sv
// Bench for ycbcr_coef_sequencer: an active-high and an active-low instance see the same
// frame timing (the low one gets inverted v_sync) and must both match the reference model.
module tb_ycbcr_coef_sequencer;

    logic clk;
    logic rst;
    logic vs;
    logic vs_n;
    int   n_vec;
    int   n_err;
    int   cyc;
    bit   tog_en;
    int   exp_active;

    int T601[9] = '{39191, 76939, 14942, -22117, -43419, 65536, 65536, -54878, -10658};
    int T709[9] = '{27866, 93743, 9463, -15017, -50519, 65536, 65536, -59527, -6009};

    assign vs_n = ~vs;

    ycbcr_coef_sequencer_if ifa ();
    ycbcr_coef_sequencer_if ifb ();

    ycbcr_coef_sequencer #(.VS_ACTIVE_HIGH(1'b1)) dut_p (
        .clk       (clk),
        .rst       (rst),
        .v_sync_in (vs),
        .bus       (ifa)
    );

    ycbcr_coef_sequencer #(.VS_ACTIVE_HIGH(1'b0)) dut_n (
        .clk       (clk),
        .rst       (rst),
        .v_sync_in (vs_n),
        .bus       (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int exp_coef(input int mode, input int idx);
        if (mode == 1) return T709[idx];
        if (mode == 2) return (idx < 3) ? T601[idx] : 0;
        return T601[idx];
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic signed [31:0] oa,
                        input logic signed [31:0] ob, input int exp);
        chk({tag, "_p"}, oa, exp);
        chk({tag, "_n"}, ob, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (tog_en && (cyc % 7 == 0)) vs = ~vs;
    endtask

    task automatic set_req(input int mode, input bit valid);
        ifa.mode_req   = 2'(mode);
        ifb.mode_req   = 2'(mode);
        ifa.mode_valid = valid;
        ifb.mode_valid = valid;
    endtask

    task automatic chk_quiet(input string tag);
        chk2({tag, "_we"}, ifa.coef_we, ifb.coef_we, 0);
        chk2({tag, "_addr"}, ifa.coef_addr, ifb.coef_addr, 0);
        chk2({tag, "_data"}, ifa.coef_data, ifb.coef_data, 0);
        chk2({tag, "_commit"}, ifa.coef_commit, ifb.coef_commit, 0);
        chk2({tag, "_err"}, ifa.cfg_err, ifb.cfg_err, 0);
    endtask

    // Arrange an inactive->active v_sync transition; the caller's next edge samples it.
    task automatic frame_start();
        if (vs) begin
            vs = 1'b0;
            step();
        end
        vs = 1'b1;
    endtask

    // Frame edge sampled at the next clock (N); writes N+1..N+9, commit N+10, ready N+11.
    task automatic expect_load(input int mode, input string tag);
        int sa[3];
        int sb[3];
        sa = '{0, 0, 0};
        sb = '{0, 0, 0};
        step();
        chk2({tag, "_edge_we"}, ifa.coef_we, ifb.coef_we, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            chk2({tag, "_we"}, ifa.coef_we, ifb.coef_we, 1);
            chk2({tag, "_addr"}, ifa.coef_addr, ifb.coef_addr, i);
            chk2({tag, "_data"}, ifa.coef_data, ifb.coef_data, exp_coef(mode, i));
            chk2({tag, "_commit_early"}, ifa.coef_commit, ifb.coef_commit, 0);
            sa[i / 3] += int'(ifa.coef_data);
            sb[i / 3] += int'(ifb.coef_data);
        end
        chk2({tag, "_sum_y"}, sa[0], sb[0], 131072);
        chk2({tag, "_sum_cb"}, sa[1], sb[1], 0);
        chk2({tag, "_sum_cr"}, sa[2], sb[2], 0);
        step();
        chk2({tag, "_commit"}, ifa.coef_commit, ifb.coef_commit, 1);
        chk2({tag, "_commit_we"}, ifa.coef_we, ifb.coef_we, 0);
        chk2({tag, "_active"}, ifa.mode_active, ifb.mode_active, mode);
        chk2({tag, "_ready_commit"}, ifa.mode_ready, ifb.mode_ready, 0);
        exp_active = mode;
        step();
        chk2({tag, "_commit_once"}, ifa.coef_commit, ifb.coef_commit, 0);
        chk2({tag, "_ready"}, ifa.mode_ready, ifb.mode_ready, 1);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        tog_en     = 1'b0;
        exp_active = 0;
        rst        = 1'b1;
        vs         = 1'b0;
        set_req(0, 1'b0);

        // Reset state.
        step();
        step();
        chk_quiet("rst");
        chk2("rst_ready", ifa.mode_ready, ifb.mode_ready, 0);
        chk2("rst_active", ifa.mode_active, ifb.mode_active, 0);

        // Power-up: first frame start loads BT.601 without any request.
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 19; i++) step();
        chk_quiet("wait_first");
        chk2("wait_first_ready", ifa.mode_ready, ifb.mode_ready, 0);
        vs = 1'b1;
        expect_load(0, "boot601");

        // BT.709 request, frame 50 cycles later; stray requests while busy are ignored.
        set_req(1, 1'b1);
        step();
        chk2("acc709_ready", ifa.mode_ready, ifb.mode_ready, 0);
        for (int i = 0; i < 50; i++) begin
            set_req(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            step();
            chk2("busy_err", ifa.cfg_err, ifb.cfg_err, 0);
            chk2("busy_we", ifa.coef_we, ifb.coef_we, 0);
        end
        set_req(0, 1'b0);
        frame_start();
        expect_load(1, "bt709");

        // Reserved mode is rejected with a single cfg_err pulse.
        vs = 1'b0;
        set_req(3, 1'b1);
        step();
        set_req(0, 1'b0);
        chk2("rsv_err", ifa.cfg_err, ifb.cfg_err, 1);
        chk2("rsv_ready", ifa.mode_ready, ifb.mode_ready, 1);
        chk2("rsv_we", ifa.coef_we, ifb.coef_we, 0);
        step();
        chk2("rsv_err_pulse", ifa.cfg_err, ifb.cfg_err, 0);
        chk2("rsv_active", ifa.mode_active, ifb.mode_active, exp_active);
        chk2("rsv_ready2", ifa.mode_ready, ifb.mode_ready, 1);

        // Luma-only with the frame edge landing on the acceptance cycle: that edge is lost.
        set_req(2, 1'b1);
        vs = 1'b1;
        step();
        set_req(0, 1'b0);
        for (int i = 0; i < 6; i++) step();
        chk_quiet("luma_skip");
        chk2("luma_skip_active", ifa.mode_active, ifb.mode_active, 1);
        frame_start();
        expect_load(2, "luma");

        // Reset after the 4th write of a BT.709 load aborts it.
        set_req(1, 1'b1);
        step();
        set_req(0, 1'b0);
        frame_start();
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk2("abort_pre_addr", ifa.coef_addr, ifb.coef_addr, i);
        end
        rst = 1'b1;
        #1;
        chk_quiet("abort");
        chk2("abort_active", ifa.mode_active, ifb.mode_active, 0);
        chk2("abort_ready", ifa.mode_ready, ifb.mode_ready, 0);
        exp_active = 0;
        vs = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk_quiet("abort_after");
        chk2("abort_after_active", ifa.mode_active, ifb.mode_active, 0);
        frame_start();
        expect_load(0, "reload601");

        // Randomized requests with v_sync toggling every 7 cycles through each load.
        for (int k = 0; k < 10; k++) begin
            int m;
            m = int'($urandom_range(0, 3));
            set_req(m, 1'b1);
            step();
            set_req(0, 1'b0);
            if (m == 3) begin
                chk2("rnd_rsv_err", ifa.cfg_err, ifb.cfg_err, 1);
                chk2("rnd_rsv_ready", ifa.mode_ready, ifb.mode_ready, 1);
                step();
                chk2("rnd_rsv_active", ifa.mode_active, ifb.mode_active, exp_active);
            end else begin
                chk2("rnd_acc_ready", ifa.mode_ready, ifb.mode_ready, 0);
                for (int i = 0; i < int'($urandom_range(1, 20)); i++) begin
                    set_req(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                    step();
                end
                set_req(0, 1'b0);
                chk_quiet("rnd_wait");
                frame_start();
                tog_en = 1'b1;
                expect_load(m, "rnd");
                for (int i = 0; i < 10; i++) begin
                    step();
                    chk2("rnd_tail_we", ifa.coef_we, ifb.coef_we, 0);
                    chk2("rnd_tail_commit", ifa.coef_commit, ifb.coef_commit, 0);
                end
                tog_en = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
